// File: rtl/sd_decim_pkg.sv
// -----------------------------------------------------------------------------
// sd_decim_pkg
//
// Purpose:
//   Shared constants, types and helpers for the sigma-delta CIC decimator
//   (sd_cic_decimator and its comb stage sd_cic_comb).
//
// Contents:
//   ORDER_DEF / DECIM_DEF / OUT_W_DEF : default filter configuration
//   acc_w()        : internal accumulator width, ORDER*log2(DECIM)+2
//   shift_amt()    : right-shift from the last comb output to the PCM word
//   acc_t          : signed accumulator type at the default configuration
//   bit_to_pm1()   : bitstream bit to +1 / -1 mapping (2-bit signed)
//
// Configuration macro:
//   SD_DECIM_SAT_EN - when defined, shift_amt() returns the full-scale shift
//                     (one bit less than half-scale) and the top saturates.
// -----------------------------------------------------------------------------
package sd_decim_pkg;

    localparam int ORDER_DEF = 3;
    localparam int DECIM_DEF = 256;
    localparam int OUT_W_DEF = 16;

    // Bit growth of an N-stage CIC with ratio R is N*log2(R); the extra two
    // bits hold the sign and the +/-1 input magnitude.
    function automatic int acc_w(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

    // Shift from accumulator width down to the output width.
    //   half-scale : |full-window sum| = 2^(ACC_W-2) maps to 2^(OUT_W-2)
    //   full-scale : the same sum maps to 2^(OUT_W-1), so +1 input saturates
    function automatic int shift_amt(input int acc, input int out_w);
`ifdef SD_DECIM_SAT_EN
        return acc - 1 - out_w;
`else
        return acc - out_w;
`endif
    endfunction

    localparam int ACC_W_DEF = acc_w(ORDER_DEF, DECIM_DEF);

    // Accumulator type at the default configuration. Instances with other
    // parameters declare their own per-instance type of width acc_w().
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    // Bitstream mapping: 1 -> +1, 0 -> -1, as a 2-bit signed value that the
    // caller sign-extends to its accumulator width.
    function automatic logic signed [1:0] bit_to_pm1(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

endpackage : sd_decim_pkg

// File: rtl/sd_cic_comb.sv
// -----------------------------------------------------------------------------
// sd_cic_comb
//
// Purpose:
//   One comb stage of the CIC decimator: dout = din - din(previous strobe).
//   The difference is combinational so that a whole chain of stages settles
//   within the decimated-rate strobe cycle; only the delay element is
//   registered, and it advances only when en_i is high.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset, clears the delay register
//   en_i    in   decimated-rate strobe; delay register loads din_i
//   din_i   in   W-bit signed stage input
//   dout_o  out  W-bit signed stage output (din_i - delay), modulo 2^W
// -----------------------------------------------------------------------------
module sd_cic_comb #(
    parameter int W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] dout_o
);

    logic signed [W-1:0] dly_q;
    logic signed [W-1:0] dly_d;

    always_comb begin
        dly_d = dly_q;
        if (en_i) begin
            dly_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    // Modulo-2^W subtraction; wrap in the integrators cancels out here.
    assign dout_o = din_i - dly_q;

endmodule : sd_cic_comb

// File: rtl/sd_cic_decimator.sv
// -----------------------------------------------------------------------------
// sd_cic_decimator
//
// Purpose:
//   Demodulates a 1-bit sigma-delta bitstream into signed PCM with an
//   ORDER-stage CIC (sinc^ORDER) decimator. Integrators run on every enabled
//   input bit; the comb chain runs once per DECIM enabled bits.
//
// Parameters:
//   ORDER  number of integrator / comb stages (1..5)
//   DECIM  decimation ratio, power of two, >= 2
//   OUT_W  output word width (signed)
//
// Ports:
//   clk          in   single clock
//   reset        in   synchronous active-high reset
//   clk_enable   in   qualifies input_rsvd; all filter state holds when low
//   input_rsvd   in   bitstream bit (1 -> +1, 0 -> -1)
//   ce_out       out  one-clock strobe marking a new output_rsvd
//   output_rsvd  out  OUT_W-bit signed decimated sample, held between strobes
//
// Timing:
//   The enabled cycle where the decimation counter is at DECIM-1 is the
//   decimation strobe. On that clock edge the comb delays update and the
//   scaled comb result is registered into output_rsvd with ce_out set, so
//   ce_out is high during the following clock only.
//
// Configuration macro:
//   SD_DECIM_SAT_EN - full-scale shift with saturation to the OUT_W range;
//                     undefined: half-scale shift, plain truncation.
// -----------------------------------------------------------------------------
module sd_cic_decimator
    import sd_decim_pkg::*;
#(
    parameter int ORDER = ORDER_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    input_rsvd,
    output logic                    ce_out,
    output logic signed [OUT_W-1:0] output_rsvd
);

    localparam int ACC_W = acc_w(ORDER, DECIM);
    localparam int SHIFT = shift_amt(ACC_W, OUT_W);
    localparam int CNT_W = $clog2(DECIM);

    typedef logic signed [ACC_W-1:0] sample_t;

    // -------------------------------------------------------------------------
    // Input mapping
    // -------------------------------------------------------------------------
    logic signed [1:0] x_pm1;
    sample_t           x_ext;

    assign x_pm1 = bit_to_pm1(input_rsvd);
    assign x_ext = {{(ACC_W-2){x_pm1[1]}}, x_pm1};

    // -------------------------------------------------------------------------
    // Decimation counter and strobe
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_stb;

    assign dec_stb = clk_enable && (cnt_q == CNT_W'(DECIM - 1));

    // DECIM is a power of two, so the counter wraps to 0 on its own.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Integrator cascade
    //   Every stage adds the *registered* value of the stage before it, so
    //   the cascade adds one clock of latency per stage. The modulo-2^ACC_W
    //   overflow is harmless because the combs difference it back out.
    // -------------------------------------------------------------------------
    sample_t integ_q [ORDER];
    sample_t integ_d [ORDER];

    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_d[gi] = clk_enable ? integ_q[gi] + x_ext
                                                : integ_q[gi];
            end else begin : g_rest
                assign integ_d[gi] = clk_enable ? integ_q[gi] + integ_q[gi-1]
                                                : integ_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= integ_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Comb chain
    //   comb_c[0] is the last integrator; comb_c[ORDER] is the filtered sum.
    //   The chain is combinational and evaluated on the strobe cycle.
    // -------------------------------------------------------------------------
    sample_t comb_c [ORDER+1];

    assign comb_c[0] = integ_q[ORDER-1];

    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_comb
            sd_cic_comb #(
                .W (ACC_W)
            ) u_comb (
                .clk    (clk),
                .reset  (reset),
                .en_i   (dec_stb),
                .din_i  (comb_c[gi]),
                .dout_o (comb_c[gi+1])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output scaling
    //   Arithmetic shift truncates toward -inf.
    // -------------------------------------------------------------------------
    logic signed [OUT_W-1:0] scaled;

`ifdef SD_DECIM_SAT_EN
    localparam sample_t SAT_HI = sample_t'((2 ** (OUT_W - 1)) - 1);
    localparam sample_t SAT_LO = -SAT_HI - sample_t'(1);

    sample_t shifted;

    assign shifted = comb_c[ORDER] >>> SHIFT;

    // A steady +1 input lands exactly one LSB above the positive limit, so
    // the clamp is needed even for legal bitstreams.
    always_comb begin
        scaled = shifted[OUT_W-1:0];
        if (shifted > SAT_HI) begin
            scaled = SAT_HI[OUT_W-1:0];
        end else if (shifted < SAT_LO) begin
            scaled = SAT_LO[OUT_W-1:0];
        end
    end
`else
    // Half-scale leaves one bit of headroom, so no clamp is required.
    assign scaled = OUT_W'(comb_c[ORDER] >>> SHIFT);
`endif

    // -------------------------------------------------------------------------
    // Output register and strobe
    // -------------------------------------------------------------------------
    logic signed [OUT_W-1:0] out_q;
    logic signed [OUT_W-1:0] out_d;
    logic                    ce_q;
    logic                    ce_d;

    always_comb begin
        out_d = out_q;
        ce_d  = dec_stb;
        if (dec_stb) begin
            out_d = scaled;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            ce_q  <= ce_d;
        end
    end

    assign output_rsvd = out_q;
    assign ce_out      = ce_q;

endmodule : sd_cic_decimator

// File: tb/tb_sd_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_sd_cic_decimator
//
// Self-checking bench for sd_cic_decimator at its default parameters.
// The reference treats the filter as a fixed FIR: the impulse response is
// the DECIM-long boxcar convolved with itself ORDER times, applied to the
// history of enabled input bits with the ORDER-sample cascade delay, then
// decimated and scaled. Honours SD_DECIM_SAT_EN for the scaling rule.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_cic_decimator;

    localparam int ORDER = 3;
    localparam int DECIM = 256;
    localparam int OUT_W = 16;
    localparam int ACC_W = ORDER * $clog2(DECIM) + 2;
`ifdef SD_DECIM_SAT_EN
    localparam int SHIFT = ACC_W - 1 - OUT_W;
    localparam bit SAT   = 1'b1;
`else
    localparam int SHIFT = ACC_W - OUT_W;
    localparam bit SAT   = 1'b0;
`endif
    localparam int HLEN  = ORDER * (DECIM - 1) + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clk_enable;
    logic                    input_rsvd;
    logic                    ce_out;
    logic signed [OUT_W-1:0] output_rsvd;

    int     n_vec = 0;
    int     n_err = 0;
    longint h [HLEN];
    int     hist [$];
    int     n_en;
    longint last_out;

    sd_cic_decimator #(
        .ORDER (ORDER),
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .input_rsvd  (input_rsvd),
        .ce_out      (ce_out),
        .output_rsvd (output_rsvd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Impulse response of sinc^ORDER with ratio DECIM.
    function automatic void build_h();
        longint tmp [HLEN];
        int     len;
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (ORDER) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < DECIM; j++)
                    tmp[i+j] += h[i];
            len += DECIM - 1;
            h = tmp;
        end
    endfunction

    // Expected PCM for the strobe on enabled sample k.
    function automatic longint model_out(input int k);
        longint y;
        longint full;
        longint lim;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            int idx;
            idx = k - ORDER - j;
            if (idx < 0) break;
            y += h[j] * longint'(hist[idx]);
        end
        full = longint'(1) << ACC_W;
        y = y & (full - 1);
        if (y >= (full >>> 1)) y -= full;
        y = y >>> SHIFT;
        if (SAT) begin
            lim = longint'(1) << (OUT_W - 1);
            if (y > lim - 1) y = lim - 1;
            if (y < -lim)    y = -lim;
        end
        return y;
    endfunction

    // Stimulus patterns indexed by enabled-sample number.
    function automatic bit pat(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (idx % 2) == 0;
            3:       return (idx % 4) != 3;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Steady-state value for the regular patterns once the window is full.
    function automatic longint lit_for(input int mode);
        case (mode)
            0:       return SAT ? 32767  : 16384;
            1:       return SAT ? -32768 : -16384;
            2:       return 0;
            default: return SAT ? 16384  : 8192;
        endcase
    endfunction

    task automatic do_reset(input int cycles);
        reset      = 1'b1;
        clk_enable = 1'b0;
        input_rsvd = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_val("rst_ce", longint'(ce_out), 0);
            check_val("rst_pcm", longint'(output_rsvd), 0);
        end
        reset    = 1'b0;
        hist.delete();
        n_en     = 0;
        last_out = 0;
    endtask

    // en_mode: 0 always enabled, 1 toggling 1,0, 2 random ~70 %.
    task automatic run(input string name, input int mode, input int en_mode, input int n_cyc);
        for (int c = 0; c < n_cyc; c++) begin
            bit     en;
            bit     x;
            bit     exp_stb;
            longint exp_v;
            en = (en_mode == 0) ? 1'b1 :
                 (en_mode == 1) ? ((c % 2) == 0) :
                                  ($urandom_range(0, 9) < 7);
            x  = pat(mode, n_en);
            clk_enable = en;
            input_rsvd = x;
            exp_stb = en && ((n_en % DECIM) == DECIM - 1);
            if (en) hist.push_back(x ? 1 : -1);
            @(posedge clk);
            #1;
            check_val({name, "_ce"}, longint'(ce_out), longint'(exp_stb));
            if (exp_stb) begin
                exp_v = model_out(n_en);
                check_val({name, "_pcm"}, longint'(output_rsvd), exp_v);
                if (mode < 4 && ((n_en + 1) / DECIM) >= ORDER + 1)
                    check_val({name, "_steady"}, longint'(output_rsvd), lit_for(mode));
                $display("%s pulse %0d: pcm=%0d model=%0d", name, (n_en + 1) / DECIM,
                         output_rsvd, exp_v);
                last_out = exp_v;
            end else begin
                check_val({name, "_hold"}, longint'(output_rsvd), last_out);
            end
            if (en) n_en++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b0;
        input_rsvd = 1'b0;
        build_h();

        do_reset(3);
        run("ones", 0, 0, 6 * DECIM);

        do_reset(1);
        run("zeros", 1, 0, 6 * DECIM);

        do_reset(1);
        run("alt", 2, 0, 6 * DECIM);

        do_reset(1);
        run("p1110", 3, 0, 6 * DECIM);

        do_reset(1);
        run("en_tog", 0, 1, 2 * 6 * DECIM);

        do_reset(1);
        run("rand", 4, 2, 8 * DECIM + 8 * DECIM / 2);

        // Reset in the middle of frame 5 (counter at 100).
        do_reset(1);
        run("pre_rst", 0, 0, 4 * DECIM + 100);
        do_reset(1);
        run("post_rst", 0, 0, 6 * DECIM);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sd_cic_decimator
